ddram_line_reader: RTL and testbench

// Core-side client of one sysmem 64-bit f2h_sdram port (ram1_*/ram2_*). Turns simple single-word core

---
 rtl/ddram_line_reader.sv | 153 +++++++++++++++
 tb/tb_ddram_line_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_line_reader.sv
// rtl/ddram_line_reader.sv - line-buffered single-word client of one sysmem f2h_sdram port
// Read misses fetch an aligned BURST-word line as one burst; read hits are served from the local buffer.
module ddram_line_reader #(
   parameter int BURST = 8
) (
   input  logic        ramclk_clk,
   input  logic        reset,
   input  logic [28:0] core_addr,
   input  logic        core_rd,
   input  logic        core_wr,
   input  logic [63:0] core_din,
   input  logic [7:0]  core_be,
   input  logic        core_flush,
   output logic        core_busy,
   output logic [63:0] core_dout,
   output logic        core_dout_valid,
   output logic [28:0] ram_address,
   output logic [7:0]  ram_burstcount,
   input  logic        ram_waitrequest,
   input  logic [63:0] ram_readdata,
   input  logic        ram_readdatavalid,
   output logic        ram_read,
   output logic [63:0] ram_writedata,
   output logic [7:0]  ram_byteenable,
   output logic        ram_write
);
   localparam int LW = $clog2(BURST);

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;
   state_t state;

   logic [63:0]   line_buf [BURST];
   logic          line_valid;
   logic [28:LW]  line_tag;
   logic [28:0]   lat_addr;
   logic [LW:0]   beat;

   logic          req_ok;
   logic          hit;
   logic          fill_beat;
   logic          last_beat;
   logic          merge_we;
   logic [LW-1:0] core_word;
   logic [LW-1:0] lat_word;
   logic [LW-1:0] beat_idx;
   logic [63:0]   merged;

   always_comb begin
      req_ok    = (state == IDLE) && !core_busy;
      core_word = core_addr[LW-1:0];
      lat_word  = lat_addr[LW-1:0];
      beat_idx  = beat[LW-1:0];
      hit       = line_valid && (line_tag == core_addr[28:LW]);
      // beats may already arrive in the acceptance cycle, so RD_REQ captures too
      fill_beat = ram_readdatavalid && ((state == RD_REQ) || (state == RD_DATA));
      last_beat = fill_beat && (beat == (LW+1)'(BURST-1));
      merge_we  = req_ok && core_wr && hit;
      merged    = '0;
      for (int b = 0; b < 8; b++) begin
         merged[8*b +: 8] = core_be[b] ? core_din[8*b +: 8] : line_buf[core_word][8*b +: 8];
      end
   end

   always_ff @(posedge ramclk_clk) begin
      if (fill_beat) begin
         line_buf[beat_idx] <= ram_readdata;
      end else if (merge_we) begin
         line_buf[core_word] <= merged;
      end
   end

   always_ff @(posedge ramclk_clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         line_valid      <= 1'b0;
         line_tag        <= '0;
         lat_addr        <= '0;
         beat            <= '0;
         core_busy       <= 1'b0;
         core_dout       <= '0;
         core_dout_valid <= 1'b0;
         ram_address     <= '0;
         ram_burstcount  <= '0;
         ram_read        <= 1'b0;
         ram_write       <= 1'b0;
         ram_writedata   <= '0;
         ram_byteenable  <= '0;
      end else begin
         core_dout_valid <= 1'b0;
         case (state)
            IDLE: begin
               core_busy <= 1'b0;
               if (req_ok && core_wr) begin
                  lat_addr       <= core_addr;
                  ram_address    <= core_addr;
                  ram_burstcount <= 8'd1;
                  ram_writedata  <= core_din;
                  ram_byteenable <= core_be;
                  ram_write      <= 1'b1;
                  core_busy      <= 1'b1;
                  state          <= WR_REQ;
               end else if (req_ok && core_rd && hit) begin
                  core_dout       <= line_buf[core_word];
                  core_dout_valid <= 1'b1;
                  core_busy       <= 1'b1;
               end else if (req_ok && core_rd) begin
                  line_valid     <= 1'b0;
                  lat_addr       <= core_addr;
                  ram_address    <= {core_addr[28:LW], LW'(0)};
                  ram_burstcount <= 8'(BURST);
                  ram_read       <= 1'b1;
                  beat           <= '0;
                  core_busy      <= 1'b1;
                  state          <= RD_REQ;
               end
            end
            WR_REQ: begin
               if (!ram_waitrequest) begin
                  ram_write <= 1'b0;
                  core_busy <= 1'b0;
                  state     <= IDLE;
               end
            end
            RD_REQ: begin
               if (!ram_waitrequest) begin
                  ram_read <= 1'b0;
                  state    <= RD_DATA;
               end
            end
            default: ;
         endcase

         if (fill_beat) begin
            if (last_beat) begin
               line_valid      <= 1'b1;
               line_tag        <= lat_addr[28:LW];
               beat            <= '0;
               // the final beat is not in line_buf yet when it is the requested word
               core_dout       <= (lat_word == LW'(BURST-1)) ? ram_readdata : line_buf[lat_word];
               core_dout_valid <= 1'b1;
               core_busy       <= 1'b0;
               state           <= IDLE;
            end else begin
               beat <= beat + (LW+1)'(1);
            end
         end

         if (core_flush) begin
            line_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ddram_line_reader.sv
// tb/tb_ddram_line_reader.sv - directed self-checking bench for ddram_line_reader
module tb_ddram_line_reader;
   logic        clk = 1'b0;
   logic        reset;
   logic [28:0] core_addr;
   logic        core_rd;
   logic        core_wr;
   logic [63:0] core_din;
   logic [7:0]  core_be;
   logic        core_flush;
   logic        core_busy;
   logic [63:0] core_dout;
   logic        core_dout_valid;
   logic [28:0] ram_address;
   logic [7:0]  ram_burstcount;
   logic        ram_waitrequest;
   logic [63:0] ram_readdata;
   logic        ram_readdatavalid;
   logic        ram_read;
   logic [63:0] ram_writedata;
   logic [7:0]  ram_byteenable;
   logic        ram_write;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] line_data [8];

   always #5 clk = ~clk;

   ddram_line_reader #(.BURST(8)) dut (
      .ramclk_clk        (clk),
      .reset             (reset),
      .core_addr         (core_addr),
      .core_rd           (core_rd),
      .core_wr           (core_wr),
      .core_din          (core_din),
      .core_be           (core_be),
      .core_flush        (core_flush),
      .core_busy         (core_busy),
      .core_dout         (core_dout),
      .core_dout_valid   (core_dout_valid),
      .ram_address       (ram_address),
      .ram_burstcount    (ram_burstcount),
      .ram_waitrequest   (ram_waitrequest),
      .ram_readdata      (ram_readdata),
      .ram_readdatavalid (ram_readdatavalid),
      .ram_read          (ram_read),
      .ram_writedata     (ram_writedata),
      .ram_byteenable    (ram_byteenable),
      .ram_write         (ram_write)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [63:0] base);
      for (int i = 0; i < 8; i++) line_data[i] = base + 64'(i) * 64'h0000_0000_0101_0101;
   endtask

   task automatic issue_rd(input logic [28:0] a);
      core_addr = a;
      core_rd   = 1'b1;
      @(negedge clk);
      core_rd   = 1'b0;
   endtask

   task automatic issue_wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
      core_addr = a;
      core_din  = d;
      core_be   = be;
      core_wr   = 1'b1;
      @(negedge clk);
      core_wr   = 1'b0;
   endtask

   // stalls the pending request for 'waits' cycles; 'early' sends beat 0 in the accept cycle
   task automatic accept(input int waits, input logic early, output int held);
      held = 0;
      for (int i = 0; i < 64 && (ram_read || ram_write); i++) begin
         held++;
         ram_waitrequest = (held <= waits);
         if (early && held > waits) begin
            ram_readdatavalid = 1'b1;
            ram_readdata      = line_data[0];
         end
         @(negedge clk);
      end
      ram_readdatavalid = 1'b0;
      ram_waitrequest   = 1'b1;
      check("accept_done", {62'd0, ram_read, ram_write}, 64'd0);
   endtask

   task automatic send_beats(input int from, input int to);
      for (int i = from; i < to; i++) begin
         ram_readdatavalid = 1'b1;
         ram_readdata      = line_data[i];
         @(negedge clk);
      end
      ram_readdatavalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          held;
      logic [63:0] exp;
      reset = 1'b1;
      core_addr = '0; core_rd = 1'b0; core_wr = 1'b0; core_din = '0; core_be = '0; core_flush = 1'b0;
      ram_waitrequest = 1'b1; ram_readdata = '0; ram_readdatavalid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(core_busy), 64'd0);
      check("rst_rd", 64'(ram_read), 64'd0);
      check("rst_wr", 64'(ram_write), 64'd0);
      check("rst_dv", 64'(core_dout_valid), 64'd0);
      check("rst_bc", 64'(ram_burstcount), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1: miss on 0x13 with 3 wait cycles
      fill(64'hA5A5_0000_0000_0000);
      issue_rd(29'h13);
      check("t1_rd", 64'(ram_read), 64'd1);
      check("t1_addr", 64'(ram_address), 64'h10);
      check("t1_bc", 64'(ram_burstcount), 64'd8);
      check("t1_busy", 64'(core_busy), 64'd1);
      accept(3, 1'b0, held);
      check("t1_held", 64'(held), 64'd4);
      send_beats(0, 7);
      check("t1_dv_early", 64'(core_dout_valid), 64'd0);
      send_beats(7, 8);
      check("t1_dv", 64'(core_dout_valid), 64'd1);
      check("t1_dout", core_dout, line_data[3]);
      @(negedge clk);
      check("t1_dv_pulse", 64'(core_dout_valid), 64'd0);

      // 2: hit on 0x15
      check("t2_busy_pre", 64'(core_busy), 64'd0);
      issue_rd(29'h15);
      check("t2_dv", 64'(core_dout_valid), 64'd1);
      check("t2_dout", core_dout, line_data[5]);
      check("t2_busy", 64'(core_busy), 64'd1);
      check("t2_rd", 64'(ram_read), 64'd0);
      @(negedge clk);
      check("t2_busy_end", 64'(core_busy), 64'd0);
      check("t2_dv_end", 64'(core_dout_valid), 64'd0);

      // 3: partial write into the line, then read it back
      issue_wr(29'h12, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      check("t3_wr", 64'(ram_write), 64'd1);
      check("t3_rd", 64'(ram_read), 64'd0);
      check("t3_bc", 64'(ram_burstcount), 64'd1);
      check("t3_addr", 64'(ram_address), 64'h12);
      check("t3_be", 64'(ram_byteenable), 64'h0F);
      accept(0, 1'b0, held);
      check("t3_held", 64'(held), 64'd1);
      check("t3_wdata_hold", ram_writedata, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t3_dv_none", 64'(core_dout_valid), 64'd0);
      issue_rd(29'h12);
      exp = {line_data[2][63:32], 32'hFFFF_FFFF};
      check("t3_merge", core_dout, exp);
      check("t3_rd_hit", 64'(ram_read), 64'd0);
      @(negedge clk);

      // 4: write outside the line with 2 wait cycles; line stays valid
      issue_wr(29'h40, 64'h0123_4567_89AB_CDEF, 8'hFF);
      check("t4_addr", 64'(ram_address), 64'h40);
      accept(2, 1'b0, held);
      check("t4_held", 64'(held), 64'd3);
      issue_rd(29'h11);
      check("t4_rd", 64'(ram_read), 64'd0);
      check("t4_dv", 64'(core_dout_valid), 64'd1);
      check("t4_dout", core_dout, line_data[1]);
      @(negedge clk);

      // 5: reset in the middle of a fill, stray beats, then a fresh burst
      issue_rd(29'h23);
      check("t5_rd", 64'(ram_read), 64'd1);
      check("t5_addr", 64'(ram_address), 64'h20);
      accept(0, 1'b0, held);
      send_beats(0, 4);
      reset = 1'b1;
      #1;
      check("t5_rst_busy", 64'(core_busy), 64'd0);
      check("t5_rst_addr", 64'(ram_address), 64'd0);
      check("t5_rst_bc", 64'(ram_burstcount), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      send_beats(4, 8);
      check("t5_stray_dv", 64'(core_dout_valid), 64'd0);
      fill(64'h5E5E_0000_0000_0000);
      issue_rd(29'h13);
      check("t5_new_rd", 64'(ram_read), 64'd1);
      check("t5_new_addr", 64'(ram_address), 64'h10);
      accept(1, 1'b0, held);
      check("t5_held", 64'(held), 64'd2);
      send_beats(0, 7);
      check("t5_dv_early", 64'(core_dout_valid), 64'd0);
      send_beats(7, 8);
      check("t5_dv", 64'(core_dout_valid), 64'd1);
      check("t5_dout", core_dout, line_data[3]);
      @(negedge clk);

      // 6: flush forces a miss; beat 0 arrives in the accept cycle
      core_flush = 1'b1;
      @(negedge clk);
      core_flush = 1'b0;
      fill(64'h3C3C_0000_0000_0000);
      issue_rd(29'h14);
      check("t6_rd", 64'(ram_read), 64'd1);
      check("t6_addr", 64'(ram_address), 64'h10);
      check("t6_bc", 64'(ram_burstcount), 64'd8);
      accept(1, 1'b1, held);
      send_beats(1, 8);
      check("t6_dv", 64'(core_dout_valid), 64'd1);
      check("t6_dout", core_dout, line_data[4]);
      @(negedge clk);
      issue_rd(29'h10);
      check("t6_w0_rd", 64'(ram_read), 64'd0);
      check("t6_w0", core_dout, line_data[0]);
      @(negedge clk);

      // flush together with the last beat: data returned, line left invalid
      fill(64'h7777_0000_0000_0000);
      issue_rd(29'h25);
      accept(0, 1'b0, held);
      send_beats(0, 7);
      core_flush = 1'b1;
      send_beats(7, 8);
      core_flush = 1'b0;
      check("t6_fl_dv", 64'(core_dout_valid), 64'd1);
      check("t6_fl_dout", core_dout, line_data[5]);
      @(negedge clk);

      // flush mid-fill: the completing fill still validates; word 7 is the bypassed last beat
      issue_rd(29'h27);
      check("t6_refetch", 64'(ram_read), 64'd1);
      accept(0, 1'b0, held);
      send_beats(0, 3);
      core_flush = 1'b1;
      send_beats(3, 4);
      core_flush = 1'b0;
      send_beats(4, 8);
      check("t6_byp_dv", 64'(core_dout_valid), 64'd1);
      check("t6_bypass", core_dout, line_data[7]);
      @(negedge clk);
      issue_rd(29'h26);
      check("t6_mid_rd", 64'(ram_read), 64'd0);
      check("t6_mid_hit", core_dout, line_data[6]);
      @(negedge clk);

      // read and write together: only the write happens
      core_addr = 29'h26; core_din = 64'hCAFE_F00D_1234_5678; core_be = 8'hFF;
      core_rd = 1'b1; core_wr = 1'b1;
      @(negedge clk);
      core_rd = 1'b0; core_wr = 1'b0;
      check("t6_both_wr", 64'(ram_write), 64'd1);
      check("t6_both_rd", 64'(ram_read), 64'd0);
      check("t6_both_dv", 64'(core_dout_valid), 64'd0);
      accept(0, 1'b0, held);
      issue_rd(29'h26);
      check("t6_both_hit", core_dout, 64'hCAFE_F00D_1234_5678);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
